// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - MIPS main control decoder with ID/EX, EX/MEM, MEM/WB control pipeline.
// Adds load-use stall, branch flush, global hold and saturating illegal-opcode tracking.
module ctrl_pipe #(
    parameter int REG_AW    = 5,
    parameter bit EN_ADDI   = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [5:0]           id_opcode,
    input  logic [REG_AW-1:0]    id_rs,
    input  logic [REG_AW-1:0]    id_rt,
    input  logic [REG_AW-1:0]    id_rd,
    output logic                 stall,
    output logic [3:0]           ex_ctrl,
    output logic [REG_AW-1:0]    ex_rt,
    output logic [2:0]           mem_ctrl,
    output logic [1:0]           wb_ctrl,
    output logic [REG_AW-1:0]    wb_dest,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic              known;
    logic [1:0]        dec_wb;
    logic [2:0]        dec_mem;
    logic [3:0]        dec_ex;
    logic [REG_AW-1:0] dec_rt;
    logic [REG_AW-1:0] dec_dest;

    logic [3:0]        idex_ex;
    logic [2:0]        idex_mem;
    logic [1:0]        idex_wb;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] idex_dest;
    logic [2:0]        exmem_mem;
    logic [1:0]        exmem_wb;
    logic [REG_AW-1:0] exmem_dest;
    logic [1:0]        memwb_wb;
    logic [REG_AW-1:0] memwb_dest;
    logic              illegal_q;
    logic [ILL_CNT_W-1:0] cnt_q;
    logic              load_dec;
    logic              ill_hit;

    always_comb begin
        known   = 1'b0;
        dec_wb  = 2'b00;
        dec_mem = 3'b000;
        dec_ex  = 4'b0000;
        case (id_opcode)
            OP_RTYPE: begin known = 1'b1; dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = 4'b1100; end
            OP_LW:    begin known = 1'b1; dec_wb = 2'b11; dec_mem = 3'b010; dec_ex = 4'b0001; end
            OP_SW:    begin known = 1'b1; dec_wb = 2'b00; dec_mem = 3'b001; dec_ex = 4'b0001; end
            OP_BEQ:   begin known = 1'b1; dec_wb = 2'b00; dec_mem = 3'b100; dec_ex = 4'b0010; end
            OP_ADDI: begin
                if (EN_ADDI) begin
                    known = 1'b1; dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = 4'b0001;
                end
            end
            default: known = 1'b0;
        endcase
        // Invalid slots and unknown opcodes both decode to an all-zero bubble.
        if (!(id_valid && known)) begin
            dec_wb  = 2'b00;
            dec_mem = 3'b000;
            dec_ex  = 4'b0000;
        end
        dec_rt   = (id_valid && known) ? id_rt : '0;
        dec_dest = (id_valid && known) ? (dec_ex[3] ? id_rd : id_rt) : '0;
    end

    // MemRead lives in idex_mem[1]; a bubble has it clear, so bubbles never stall.
    assign stall = id_valid && idex_mem[1] && ((idex_rt == id_rs) || (idex_rt == id_rt))
                   && !flush && !rst;

    assign load_dec = !flush && !stall;
    assign ill_hit  = load_dec && id_valid && !known;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ex    <= '0;
            idex_mem   <= '0;
            idex_wb    <= '0;
            idex_rt    <= '0;
            idex_dest  <= '0;
            exmem_mem  <= '0;
            exmem_wb   <= '0;
            exmem_dest <= '0;
            memwb_wb   <= '0;
            memwb_dest <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (!hold) begin
            memwb_wb   <= exmem_wb;
            memwb_dest <= exmem_dest;
            if (flush) begin
                exmem_mem  <= '0;
                exmem_wb   <= '0;
                exmem_dest <= '0;
            end else begin
                exmem_mem  <= idex_mem;
                exmem_wb   <= idex_wb;
                exmem_dest <= idex_dest;
            end
            if (load_dec) begin
                idex_ex   <= dec_ex;
                idex_mem  <= dec_mem;
                idex_wb   <= dec_wb;
                idex_rt   <= dec_rt;
                idex_dest <= dec_dest;
            end else begin
                idex_ex   <= '0;
                idex_mem  <= '0;
                idex_wb   <= '0;
                idex_rt   <= '0;
                idex_dest <= '0;
            end
            illegal_q <= ill_hit;
            if (ill_hit && (cnt_q != {ILL_CNT_W{1'b1}}))
                cnt_q <= cnt_q + ILL_CNT_W'(1);
        end
    end

    assign ex_ctrl     = idex_ex;
    assign ex_rt       = idex_rt;
    assign mem_ctrl    = exmem_mem;
    assign wb_ctrl     = memwb_wb;
    assign wb_dest     = memwb_dest;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;
endmodule
